// File: rtl/fyp_reception_if.sv
// Stream bundle between the MAC RX Avalon-ST source and the payload sink.
// Latency: none; wires only.
// Backpressure: eth_ast_rx_rdy flows back to the MAC; the payload side takes no backpressure.
interface fyp_reception_if;
  logic [31:0] eth_ast_rx_data;
  logic        eth_ast_rx_valid;
  logic        eth_ast_rx_sop;
  logic        eth_ast_rx_eop;
  logic [1:0]  eth_ast_rx_empty;
  logic [5:0]  eth_ast_rx_err;
  logic        eth_ast_rx_rdy;

  logic [31:0] pl_data;
  logic        pl_valid;
  logic        pl_sop;
  logic        pl_eop;
  logic        pl_err;
  logic [1:0]  pl_empty;

  // MAC / bench side: drives RX beats, observes ready and the payload stream
  modport master (
    output eth_ast_rx_data, eth_ast_rx_valid, eth_ast_rx_sop, eth_ast_rx_eop,
    output eth_ast_rx_empty, eth_ast_rx_err,
    input  eth_ast_rx_rdy,
    input  pl_data, pl_valid, pl_sop, pl_eop, pl_err, pl_empty
  );

  // Receiver side: consumes RX beats, sources the realigned payload stream
  modport slave (
    input  eth_ast_rx_data, eth_ast_rx_valid, eth_ast_rx_sop, eth_ast_rx_eop,
    input  eth_ast_rx_empty, eth_ast_rx_err,
    output eth_ast_rx_rdy,
    output pl_data, pl_valid, pl_sop, pl_eop, pl_err, pl_empty
  );
endinterface

// File: rtl/fyp_reception.sv
// Parses Ethernet/IPv4/UDP frames from a 32-bit RX stream, filters on MAC/type/port and realigns the UDP payload.
// Latency: header fields and payload beats are registered one cycle after the accepting beat; a short eop adds one FLUSH beat.
// Backpressure: no backpressure from the payload side; eth_ast_rx_rdy drops only for the FLUSH cycle and during reset.
module fyp_reception #(
  parameter logic [47:0] LOCAL_MAC  = 48'h001C23174ACB,
  parameter logic [15:0] LOCAL_PORT = 16'h0000
) (
  input  logic                  clk,
  input  logic                  reset,
  fyp_reception_if.slave        eth,
  output logic [47:0]           mac_src_out,
  output logic [31:0]           ip_src_out,
  output logic [15:0]           udp_src_out,
  output logic [15:0]           udp_dst_out,
  output logic [15:0]           udp_length_out,
  output logic                  hdr_valid,
  output logic [15:0]           rx_pkt_count,
  output logic [15:0]           rx_drop_count,
  output logic [15:0]           rx_err_count
);
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_HDR     = 3'd1;
  localparam logic [2:0] S_PAYLOAD = 3'd2;
  localparam logic [2:0] S_FLUSH   = 3'd3;
  localparam logic [2:0] S_DROP    = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic        fail_q, fail_d;        // sticky filter failure for the frame in HDR
  logic        first_q, first_d;      // next payload beat is the first one
  logic [15:0] hold_q, hold_d;        // trailing half-word awaiting realignment
  logic [1:0]  fl_empty_q, fl_empty_d;
  logic        fl_err_q, fl_err_d;
  logic [31:0] dmac_hi_q, dmac_hi_d;
  logic [47:0] smac_q, smac_d;
  logic [31:0] ipsrc_q, ipsrc_d;
  logic [15:0] usrc_q, usrc_d, udst_q, udst_d, ulen_q, ulen_d;
  logic [47:0] mac_src_q, mac_src_d;
  logic [31:0] ip_src_q, ip_src_d;
  logic [15:0] udp_src_q, udp_src_d, udp_dst_q, udp_dst_d, udp_len_q, udp_len_d;
  logic        hdr_valid_q, hdr_valid_d;
  logic [31:0] pl_data_q, pl_data_d;
  logic        pl_valid_q, pl_valid_d, pl_sop_q, pl_sop_d, pl_eop_q, pl_eop_d, pl_err_q, pl_err_d;
  logic [1:0]  pl_empty_q, pl_empty_d;
  logic [15:0] pkt_cnt_q, pkt_cnt_d, drop_cnt_q, drop_cnt_d, err_cnt_q, err_cnt_d;
  logic [1:0]  drop_inc;
  logic        pkt_inc, err_inc;

  logic        rx_rdy, rx_acc, rx_bad;
  logic [31:0] word;
  logic [1:0]  e;

  assign rx_rdy = reset && (state_q != S_FLUSH);
  assign rx_acc = eth.eth_ast_rx_valid && rx_rdy;
  assign word   = eth.eth_ast_rx_data;
  assign e      = eth.eth_ast_rx_empty;
  assign rx_bad = |eth.eth_ast_rx_err;

  function automatic logic [15:0] sat_add(input logic [15:0] c, input logic [1:0] n);
    logic [16:0] s;
    s = {1'b0, c} + {15'd0, n};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  // Next-state, header capture, payload realignment and statistics
  always_comb begin
    state_d = state_q;  idx_d = idx_q;  fail_d = fail_q;  first_d = first_q;  hold_d = hold_q;
    fl_empty_d = fl_empty_q;  fl_err_d = fl_err_q;  dmac_hi_d = dmac_hi_q;
    smac_d = smac_q;  ipsrc_d = ipsrc_q;  usrc_d = usrc_q;  udst_d = udst_q;  ulen_d = ulen_q;
    mac_src_d = mac_src_q;  ip_src_d = ip_src_q;  udp_src_d = udp_src_q;
    udp_dst_d = udp_dst_q;  udp_len_d = udp_len_q;
    hdr_valid_d = 1'b0;
    pl_data_d = pl_data_q;  pl_valid_d = 1'b0;  pl_sop_d = 1'b0;  pl_eop_d = 1'b0;
    pl_err_d = 1'b0;  pl_empty_d = 2'd0;
    drop_inc = 2'd0;  pkt_inc = 1'b0;  err_inc = 1'b0;

    if (state_q == S_FLUSH) begin
      pl_valid_d = 1'b1;
      pl_data_d  = {hold_q, 16'h0000};
      pl_eop_d   = 1'b1;
      pl_empty_d = 2'd2 + fl_empty_q;
      pl_err_d   = fl_err_q;
      err_inc    = fl_err_q;
      pkt_inc    = !fl_err_q;
      state_d    = S_IDLE;
    end else if (rx_acc) begin
      if (eth.eth_ast_rx_sop) begin
        // A new sop aborts whatever frame was in flight
        if (state_q != S_IDLE) drop_inc = drop_inc + 2'd1;
        if (state_q == S_PAYLOAD) begin
          pl_valid_d = 1'b1;
          pl_data_d  = {hold_q, 16'h0000};
          pl_sop_d   = first_q;
          pl_eop_d   = 1'b1;
          pl_err_d   = 1'b1;
          pl_empty_d = 2'd2;
        end
        dmac_hi_d = word;
        fail_d    = 1'b0;
        idx_d     = 4'd1;
        state_d   = S_HDR;
        if (eth.eth_ast_rx_eop) begin
          drop_inc = drop_inc + 2'd1;
          idx_d    = 4'd0;
          state_d  = S_IDLE;
        end
      end else begin
        case (state_q)
          S_HDR: begin
            case (idx_q)
              4'd1: begin
                if ({dmac_hi_q, word[31:16]} != LOCAL_MAC &&
                    {dmac_hi_q, word[31:16]} != 48'hFFFF_FFFF_FFFF) fail_d = 1'b1;
                smac_d[47:32] = word[15:0];
              end
              4'd2: smac_d[31:0] = word;
              4'd3: if (word[31:16] != 16'h0800 || word[15:8] != 8'h45) fail_d = 1'b1;
              4'd5: if (word[7:0] != 8'h11) fail_d = 1'b1;
              4'd6: ipsrc_d[31:16] = word[15:0];
              4'd7: ipsrc_d[15:0] = word[31:16];
              4'd8: usrc_d = word[15:0];
              4'd9: begin
                udst_d = word[31:16];
                ulen_d = word[15:0];
                if (LOCAL_PORT != 16'h0000 && word[31:16] != LOCAL_PORT) fail_d = 1'b1;
              end
              default: ;
            endcase
            if (idx_q == 4'd10) begin
              idx_d = 4'd0;
              if (fail_q) begin
                if (eth.eth_ast_rx_eop) begin
                  drop_inc = drop_inc + 2'd1;
                  state_d  = S_IDLE;
                end else begin
                  state_d  = S_DROP;
                end
              end else begin
                mac_src_d = smac_q;  ip_src_d = ipsrc_q;  udp_src_d = usrc_q;
                udp_dst_d = udst_q;  udp_len_d = ulen_q;
                hdr_valid_d = 1'b1;
                if (eth.eth_ast_rx_eop) begin
                  // Payload of at most two bytes lives entirely in this word
                  if (e < 2'd2) begin
                    pl_valid_d = 1'b1;
                    pl_data_d  = {word[15:0], 16'h0000};
                    pl_sop_d   = 1'b1;
                    pl_eop_d   = 1'b1;
                    pl_empty_d = 2'd2 + e;
                    pl_err_d   = rx_bad;
                  end
                  err_inc = rx_bad;
                  pkt_inc = !rx_bad;
                  state_d = S_IDLE;
                end else begin
                  hold_d  = word[15:0];
                  first_d = 1'b1;
                  state_d = S_PAYLOAD;
                end
              end
            end else if (eth.eth_ast_rx_eop) begin
              drop_inc = drop_inc + 2'd1;
              idx_d    = 4'd0;
              state_d  = S_IDLE;
            end else begin
              idx_d = idx_q + 4'd1;
            end
          end
          S_PAYLOAD: begin
            pl_valid_d = 1'b1;
            pl_data_d  = {hold_q, word[31:16]};
            pl_sop_d   = first_q;
            first_d    = 1'b0;
            hold_d     = word[15:0];
            if (eth.eth_ast_rx_eop) begin
              if (e >= 2'd2) begin
                pl_eop_d   = 1'b1;
                pl_empty_d = e - 2'd2;
                pl_err_d   = rx_bad;
                err_inc    = rx_bad;
                pkt_inc    = !rx_bad;
                state_d    = S_IDLE;
              end else begin
                // Lower half-word still holds payload: emit it in a FLUSH cycle
                fl_empty_d = e;
                fl_err_d   = rx_bad;
                state_d    = S_FLUSH;
              end
            end
          end
          S_DROP: begin
            if (eth.eth_ast_rx_eop) begin
              drop_inc = drop_inc + 2'd1;
              state_d  = S_IDLE;
            end
          end
          default: ;  // IDLE ignores beats without sop
        endcase
      end
    end

    pkt_cnt_d  = sat_add(pkt_cnt_q, {1'b0, pkt_inc});
    err_cnt_d  = sat_add(err_cnt_q, {1'b0, err_inc});
    drop_cnt_d = sat_add(drop_cnt_q, drop_inc);
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;  idx_q <= 4'd0;  fail_q <= 1'b0;  first_q <= 1'b0;  hold_q <= 16'h0;
      fl_empty_q <= 2'd0;  fl_err_q <= 1'b0;  dmac_hi_q <= 32'h0;
      smac_q <= 48'h0;  ipsrc_q <= 32'h0;  usrc_q <= 16'h0;  udst_q <= 16'h0;  ulen_q <= 16'h0;
      mac_src_q <= 48'h0;  ip_src_q <= 32'h0;  udp_src_q <= 16'h0;  udp_dst_q <= 16'h0;
      udp_len_q <= 16'h0;  hdr_valid_q <= 1'b0;
      pl_data_q <= 32'h0;  pl_valid_q <= 1'b0;  pl_sop_q <= 1'b0;  pl_eop_q <= 1'b0;
      pl_err_q <= 1'b0;  pl_empty_q <= 2'd0;
      pkt_cnt_q <= 16'h0;  drop_cnt_q <= 16'h0;  err_cnt_q <= 16'h0;
    end else begin
      state_q <= state_d;  idx_q <= idx_d;  fail_q <= fail_d;  first_q <= first_d;  hold_q <= hold_d;
      fl_empty_q <= fl_empty_d;  fl_err_q <= fl_err_d;  dmac_hi_q <= dmac_hi_d;
      smac_q <= smac_d;  ipsrc_q <= ipsrc_d;  usrc_q <= usrc_d;  udst_q <= udst_d;  ulen_q <= ulen_d;
      mac_src_q <= mac_src_d;  ip_src_q <= ip_src_d;  udp_src_q <= udp_src_d;  udp_dst_q <= udp_dst_d;
      udp_len_q <= udp_len_d;  hdr_valid_q <= hdr_valid_d;
      pl_data_q <= pl_data_d;  pl_valid_q <= pl_valid_d;  pl_sop_q <= pl_sop_d;  pl_eop_q <= pl_eop_d;
      pl_err_q <= pl_err_d;  pl_empty_q <= pl_empty_d;
      pkt_cnt_q <= pkt_cnt_d;  drop_cnt_q <= drop_cnt_d;  err_cnt_q <= err_cnt_d;
    end
  end

  assign eth.eth_ast_rx_rdy = rx_rdy;
  assign eth.pl_data        = pl_data_q;
  assign eth.pl_valid       = pl_valid_q;
  assign eth.pl_sop         = pl_sop_q;
  assign eth.pl_eop         = pl_eop_q;
  assign eth.pl_err         = pl_err_q;
  assign eth.pl_empty       = pl_empty_q;
  assign mac_src_out        = mac_src_q;
  assign ip_src_out         = ip_src_q;
  assign udp_src_out        = udp_src_q;
  assign udp_dst_out        = udp_dst_q;
  assign udp_length_out     = udp_len_q;
  assign hdr_valid          = hdr_valid_q;
  assign rx_pkt_count       = pkt_cnt_q;
  assign rx_drop_count      = drop_cnt_q;
  assign rx_err_count       = err_cnt_q;
endmodule

// File: tb/tb_fyp_reception.sv
// Bench for fyp_reception: frame table with hand-derived expectations, hand sequences, randomized frames vs byte-level model.
// Latency: outputs sampled on the falling edge, one cycle after the accepting beat.
// Backpressure: the driver holds each beat until eth_ast_rx_rdy is seen high.
module tb_fyp_reception;
  localparam logic [47:0] MAC  = 48'h001C23174ACB;
  localparam logic [15:0] PORT = 16'd5000;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  fyp_reception_if bus();
  logic [47:0] mac_src_out;
  logic [31:0] ip_src_out;
  logic [15:0] udp_src_out, udp_dst_out, udp_length_out;
  logic        hdr_valid;
  logic [15:0] rx_pkt_count, rx_drop_count, rx_err_count;

  fyp_reception #(.LOCAL_MAC(MAC), .LOCAL_PORT(PORT)) dut (
    .clk(clk), .reset(reset), .eth(bus),
    .mac_src_out(mac_src_out), .ip_src_out(ip_src_out), .udp_src_out(udp_src_out),
    .udp_dst_out(udp_dst_out), .udp_length_out(udp_length_out), .hdr_valid(hdr_valid),
    .rx_pkt_count(rx_pkt_count), .rx_drop_count(rx_drop_count), .rx_err_count(rx_err_count)
  );

  typedef struct packed { logic [31:0] data; logic sop; logic eop; logic err; logic [1:0] empty; } beat_t;
  typedef struct packed { logic [47:0] mac; logic [31:0] ip; logic [15:0] sp; logic [15:0] dp; logic [15:0] ln; } hdr_t;
  typedef struct {
    int len; logic [15:0] et; logic [5:0] err; bit bad_port; bit bcast;
    int n_beats; int n_hdr; int last_empty; int pkt; int drop; int errc; int flush;
  } vec_t;

  beat_t got_q[$], exp_q[$];
  hdr_t  got_h[$], exp_h[$];
  logic [7:0] fb[$];
  int n_vec = 0, n_bad = 0;
  int exp_pkt = 0, exp_drop = 0, exp_err = 0, rdy_low = 0;
  vec_t tbl[10];

  // Output monitor
  always @(negedge clk) begin
    if (reset) begin
      if (bus.pl_valid) got_q.push_back({bus.pl_data, bus.pl_sop, bus.pl_eop, bus.pl_err, bus.pl_empty});
      if (hdr_valid) got_h.push_back({mac_src_out, ip_src_out, udp_src_out, udp_dst_out, udp_length_out});
      if (!bus.eth_ast_rx_rdy) rdy_low++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int sat(input int c);
    return (c < 65535) ? c + 1 : c;
  endfunction

  function automatic logic [7:0] fbyte(input int i);
    return (i < fb.size()) ? fb[i] : 8'h00;
  endfunction

  task automatic setb(input int i, input logic [7:0] v);
    if (i < fb.size()) fb[i] = v;
  endtask

  task automatic build(input int len, input logic [47:0] dmac, input logic [15:0] et,
                       input logic [7:0] vi, input logic [7:0] pr, input logic [15:0] dport);
    fb.delete();
    for (int i = 0; i < len; i++) fb.push_back(8'($urandom));
    for (int i = 0; i < 6; i++) setb(i, dmac[47-8*i -: 8]);
    setb(12, et[15:8]);  setb(13, et[7:0]);  setb(14, vi);  setb(23, pr);
    setb(36, dport[15:8]);  setb(37, dport[7:0]);
  endtask

  function automatic bit pass_f();
    logic [47:0] d;
    d = {fb[0], fb[1], fb[2], fb[3], fb[4], fb[5]};
    return (d == MAC || d == 48'hFFFF_FFFF_FFFF) && {fb[12], fb[13]} == 16'h0800 &&
           fb[14] == 8'h45 && fb[23] == 8'h11 && (PORT == 16'h0 || {fb[36], fb[37]} == PORT);
  endfunction

  // Byte-level reference: payload is bytes 42..n-1 chopped into 4-byte beats
  task automatic model(input bit aborted, input logic [5:0] err);
    int n;
    beat_t b;
    n = fb.size();
    if ((n + 3) / 4 < 11 || !pass_f()) begin
      exp_drop = sat(exp_drop);
      return;
    end
    exp_h.push_back({fb[6], fb[7], fb[8], fb[9], fb[10], fb[11], fb[26], fb[27], fb[28], fb[29],
                     fb[34], fb[35], fb[36], fb[37], fb[38], fb[39]});
    for (int i = 42; i < n; i += 4) begin
      b.data  = {fbyte(i), fbyte(i+1), fbyte(i+2), fbyte(i+3)};
      b.empty = (i + 4 > n) ? 2'(i + 4 - n) : 2'd0;
      b.sop   = (i == 42);
      b.eop   = (i + 4 >= n);
      b.err   = b.eop && (aborted || err != 6'd0);
      exp_q.push_back(b);
    end
    if (aborted) exp_drop = sat(exp_drop);
    else if (err != 6'd0) exp_err = sat(exp_err);
    else exp_pkt = sat(exp_pkt);
  endtask

  task automatic push_beat();
    int t;
    bit ok;
    t = 0;
    ok = 1'b0;
    while (!ok) begin
      @(negedge clk);
      ok = bus.eth_ast_rx_rdy;
      @(posedge clk);
      #1;
      t++;
      if (!ok && t > 8) begin
        n_vec++;
        n_bad++;
        $display("FAIL rdy_timeout: got rdy=0 for %0d cycles expected rdy=1", t);
        ok = 1'b1;
      end
    end
  endtask

  task automatic idle_bus();
    bus.eth_ast_rx_valid = 1'b0;  bus.eth_ast_rx_sop = 1'b0;  bus.eth_ast_rx_eop = 1'b0;
    bus.eth_ast_rx_empty = 2'd0;  bus.eth_ast_rx_err = 6'd0;
  endtask

  task automatic send(input bit aborted, input logic [5:0] err, input int cut, input bit gaps);
    int n, nb;
    n = fb.size();
    nb = (n + 3) / 4;
    for (int w = 0; w < nb; w++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        idle_bus();
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
      end
      bus.eth_ast_rx_data  = {fbyte(4*w), fbyte(4*w+1), fbyte(4*w+2), fbyte(4*w+3)};
      bus.eth_ast_rx_valid = 1'b1;
      bus.eth_ast_rx_sop   = (w == 0);
      bus.eth_ast_rx_eop   = (w == nb - 1) && !aborted;
      bus.eth_ast_rx_empty = bus.eth_ast_rx_eop ? 2'(4*nb - n) : 2'd0;
      bus.eth_ast_rx_err   = bus.eth_ast_rx_eop ? err : 6'd0;
      if (w == cut) begin
        reset = 1'b0;
        @(posedge clk);
        #1;
        return;
      end
      push_beat();
    end
    idle_bus();
  endtask

  task automatic do_reset();
    idle_bus();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    exp_pkt = 0;  exp_drop = 0;  exp_err = 0;  rdy_low = 0;
    got_q.delete();  exp_q.delete();  got_h.delete();  exp_h.delete();
  endtask

  task automatic drain();
    idle_bus();
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, "/pl_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) chk({tag, "/pl_beat"}, got_q[i], exp_q[i]);
    chk({tag, "/hdr_count"}, got_h.size(), exp_h.size());
    for (int i = 0; i < exp_h.size() && i < got_h.size(); i++) chk({tag, "/hdr_fields"}, got_h[i], exp_h[i]);
    chk({tag, "/pkt_count"}, rx_pkt_count, exp_pkt);
    chk({tag, "/drop_count"}, rx_drop_count, exp_drop);
    chk({tag, "/err_count"}, rx_err_count, exp_err);
    got_q.delete();  exp_q.delete();  got_h.delete();  exp_h.delete();
  endtask

  initial begin
    bit prev_abort;
    tbl[0] = '{60, 16'h0800, 6'd0,  1'b0, 1'b0, 5, 1, 2, 1, 0, 0, 1};
    tbl[1] = '{58, 16'h0800, 6'd0,  1'b0, 1'b0, 4, 1, 0, 1, 0, 0, 0};
    tbl[2] = '{60, 16'h0806, 6'd0,  1'b0, 1'b0, 0, 0, 0, 0, 1, 0, 0};
    tbl[3] = '{60, 16'h0800, 6'h01, 1'b0, 1'b0, 5, 1, 2, 0, 0, 1, 1};
    tbl[4] = '{32, 16'h0800, 6'd0,  1'b0, 1'b0, 0, 0, 0, 0, 1, 0, 0};
    tbl[5] = '{60, 16'h0800, 6'd0,  1'b1, 1'b0, 0, 0, 0, 0, 1, 0, 0};
    tbl[6] = '{44, 16'h0800, 6'd0,  1'b0, 1'b0, 1, 1, 2, 1, 0, 0, 0};
    tbl[7] = '{42, 16'h0800, 6'd0,  1'b0, 1'b0, 0, 1, 0, 1, 0, 0, 0};
    tbl[8] = '{64, 16'h0800, 6'd0,  1'b0, 1'b1, 6, 1, 2, 1, 0, 0, 1};
    tbl[9] = '{59, 16'h0800, 6'd0,  1'b0, 1'b0, 5, 1, 3, 1, 0, 0, 1};

    // Reset state
    idle_bus();
    bus.eth_ast_rx_data = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset/rdy", bus.eth_ast_rx_rdy, 1'b0);
    chk("reset/pl_valid_hdr_valid", {bus.pl_valid, hdr_valid}, 2'b00);
    chk("reset/counters", {rx_pkt_count, rx_drop_count, rx_err_count}, 48'h0);
    chk("reset/header", {mac_src_out, ip_src_out, udp_src_out, udp_dst_out, udp_length_out}, 128'h0);

    // Frame table
    for (int r = 0; r < 10; r++) begin
      do_reset();
      build(tbl[r].len, tbl[r].bcast ? 48'hFFFF_FFFF_FFFF : MAC, tbl[r].et, 8'h45, 8'h11,
            tbl[r].bad_port ? PORT + 16'd1 : PORT);
      model(1'b0, tbl[r].err);
      send(1'b0, tbl[r].err, -1, 1'b0);
      drain();
      chk($sformatf("tbl%0d/n_beats", r), got_q.size(), tbl[r].n_beats);
      chk($sformatf("tbl%0d/n_hdr", r), got_h.size(), tbl[r].n_hdr);
      if (tbl[r].n_beats > 0 && got_q.size() > 0)
        chk($sformatf("tbl%0d/last_empty", r), got_q[got_q.size()-1].empty, tbl[r].last_empty);
      chk($sformatf("tbl%0d/counts", r), {rx_pkt_count, rx_drop_count, rx_err_count},
          {16'(tbl[r].pkt), 16'(tbl[r].drop), 16'(tbl[r].errc)});
      chk($sformatf("tbl%0d/rdy_low_cycles", r), rdy_low, tbl[r].flush);
      check_model($sformatf("tbl%0d", r));
    end

    // New sop in the middle of the payload, then a clean frame
    do_reset();
    build(52, MAC, 16'h0800, 8'h45, 8'h11, PORT);
    model(1'b1, 6'd0);
    send(1'b1, 6'd0, -1, 1'b0);
    build(60, MAC, 16'h0800, 8'h45, 8'h11, PORT);
    model(1'b0, 6'd0);
    send(1'b0, 6'd0, -1, 1'b0);
    drain();
    chk("abort/drop_then_pkt", {rx_pkt_count, rx_drop_count}, {16'd1, 16'd1});
    check_model("abort");

    // Reset asserted while beat 12 is on the bus
    do_reset();
    build(60, MAC, 16'h0800, 8'h45, 8'h11, PORT);
    send(1'b0, 6'd0, 11, 1'b0);
    chk("midreset/rdy", bus.eth_ast_rx_rdy, 1'b0);
    chk("midreset/pl", {bus.pl_valid, bus.pl_sop, bus.pl_eop, bus.pl_err, bus.pl_empty, bus.pl_data}, 38'h0);
    chk("midreset/hdr", {hdr_valid, mac_src_out, ip_src_out, udp_src_out, udp_dst_out, udp_length_out}, 129'h0);
    chk("midreset/counters", {rx_pkt_count, rx_drop_count, rx_err_count}, 48'h0);
    idle_bus();
    @(posedge clk);
    #1;
    reset = 1'b1;
    exp_pkt = 0;  exp_drop = 0;  exp_err = 0;
    got_q.delete();  exp_q.delete();  got_h.delete();  exp_h.delete();
    build(60, MAC, 16'h0800, 8'h45, 8'h11, PORT);
    model(1'b0, 6'd0);
    send(1'b0, 6'd0, -1, 1'b0);
    drain();
    check_model("after_reset");

    // Randomized frames with gaps, junk beats and aborts
    do_reset();
    prev_abort = 1'b0;
    for (int k = 0; k < 40; k++) begin
      int len;
      bit ab;
      logic [47:0] dm;
      logic [5:0] er;
      len = $urandom_range(30, 90);
      ab  = ($urandom_range(0, 5) == 0);
      if (ab) len = len & ~3;
      case ($urandom_range(0, 5))
        0:       dm = 48'hFFFF_FFFF_FFFF;
        1:       dm = {16'($urandom), 32'($urandom)};
        default: dm = MAC;
      endcase
      er = ($urandom_range(0, 6) == 0) ? 6'($urandom_range(1, 63)) : 6'd0;
      if (!prev_abort && $urandom_range(0, 4) == 0) begin
        bus.eth_ast_rx_data  = $urandom;
        bus.eth_ast_rx_valid = 1'b1;
        bus.eth_ast_rx_sop   = 1'b0;
        bus.eth_ast_rx_eop   = 1'($urandom_range(0, 1));
        push_beat();
        idle_bus();
      end
      build(len, dm, ($urandom_range(0, 9) == 0) ? 16'h86DD : 16'h0800,
            ($urandom_range(0, 19) == 0) ? 8'h46 : 8'h45,
            ($urandom_range(0, 9) == 0) ? 8'h06 : 8'h11,
            ($urandom_range(0, 4) == 0) ? 16'($urandom) : PORT);
      model(ab, er);
      send(ab, er, -1, 1'b1);
      prev_abort = ab;
    end
    build(60, MAC, 16'h0800, 8'h45, 8'h11, PORT);
    model(1'b0, 6'd0);
    send(1'b0, 6'd0, -1, 1'b1);
    drain();
    check_model("random");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
